rr_ring_arbiter: RTL and testbench

Round-robin arbiter that shares one resource among N requesters using a one-hot rotating priority pointer, the same ring-shift structure as the team's ring counter. A requester holds `req` high for as long as it uses the resource. The arbiter issues a registered one-hot grant and hands off to the next requester with no gap. An optional hold limit forces rotation so that one requester cannot starve the others. It sits between the requesting engines and the shared datapath or bus port.

---
 rtl/rr_ring_arbiter_if.sv | 29 ++
 rtl/rr_ring_arbiter.sv | 131 +++++++++++++
 tb/tb_rr_ring_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/rr_ring_arbiter_if.sv
// Request/grant bundle between the requesting engines and the round-robin arbiter.
// The arbiter drives grant, grant_valid, grant_idx and ptr; the requesters drive req.
interface rr_ring_arbiter_if #(
  parameter int N = 4
);
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]    req;
  logic [N-1:0]    grant;
  logic            grant_valid;
  logic [IDXW-1:0] grant_idx;
  logic [N-1:0]    ptr;

  modport master (
    output req,
    input  grant,
    input  grant_valid,
    input  grant_idx,
    input  ptr
  );

  modport slave (
    input  req,
    output grant,
    output grant_valid,
    output grant_idx,
    output ptr
  );
endinterface

// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority pointer, registered one-hot grant,
// zero-gap handoff on release, and an optional hold limit that forces rotation.
module rr_ring_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  rr_ring_arbiter_if.slave   arb
);
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam int HCW  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  localparam logic [IDXW:0]   N_W      = (IDXW + 1)'(N);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);
  localparam logic [HCW-1:0]  HOLD_LIM = HCW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OWNED = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic            grant_valid_q, grant_valid_d;
  logic [IDXW-1:0] grant_idx_q, grant_idx_d;
  logic [N-1:0]    ptr_q, ptr_d;
  logic [HCW-1:0]  hold_cnt_q, hold_cnt_d;

  logic [N-1:0]    cand;
  logic [IDXW-1:0] ptr_idx;
  logic [IDXW:0]   pos;
  logic            win_found;
  logic [IDXW-1:0] win_idx;
  logic [IDXW-1:0] nxt_idx;
  logic [N-1:0]    win_oh;
  logic [N-1:0]    nxt_ptr;

  // Circular search starting at the pointer; the owner is never its own candidate.
  always_comb begin
    cand      = arb.req & ~grant_q;
    ptr_idx   = '0;
    pos       = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (ptr_q[k]) ptr_idx = k[IDXW-1:0];
    end
    for (int i = N - 1; i >= 0; i--) begin
      pos = {1'b0, ptr_idx} + i[IDXW:0];
      if (pos >= N_W) pos = pos - N_W;
      if (cand[pos[IDXW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = pos[IDXW-1:0];
      end
    end
    nxt_idx          = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
    win_oh           = '0;
    win_oh[win_idx]  = 1'b1;
    nxt_ptr          = '0;
    nxt_ptr[nxt_idx] = 1'b1;
  end

  logic owner_req;
  logic others_req;
  logic hold_sat;
  logic take;

  always_comb begin
    owner_req     = |(arb.req & grant_q);
    others_req    = |cand;
    hold_sat      = (MAX_HOLD > 0) && (hold_cnt_q == HOLD_LIM);
    take          = 1'b0;
    state_d       = state_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    grant_idx_d   = grant_idx_q;
    ptr_d         = ptr_q;
    hold_cnt_d    = hold_cnt_q;

    if (state_q == ST_IDLE) begin
      take       = win_found;
      hold_cnt_d = '0;
    end else if (!owner_req) begin
      // Release: hand off in the same edge, or fall back to idle.
      if (win_found) begin
        take = 1'b1;
      end else begin
        state_d       = ST_IDLE;
        grant_d       = '0;
        grant_valid_d = 1'b0;
        grant_idx_d   = '0;
        hold_cnt_d    = '0;
      end
    end else if (hold_sat && others_req) begin
      take = 1'b1;
    end else if (MAX_HOLD > 0 && !hold_sat) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end

    if (take) begin
      state_d       = ST_OWNED;
      grant_d       = win_oh;
      grant_valid_d = 1'b1;
      grant_idx_d   = win_idx;
      ptr_d         = nxt_ptr;
      hold_cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
      ptr_q         <= {{(N-1){1'b0}}, 1'b1};
      hold_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_idx_q   <= grant_idx_d;
      ptr_q         <= ptr_d;
      hold_cnt_q    <= hold_cnt_d;
    end
  end

  assign arb.grant       = grant_q;
  assign arb.grant_valid = grant_valid_q;
  assign arb.grant_idx   = grant_idx_q;
  assign arb.ptr         = ptr_q;
endmodule

// File: tb/tb_rr_ring_arbiter.sv
// Directed bench for rr_ring_arbiter: a vector table plus hand-written sequences for
// reset, hold-limit rotation, lone owner and the no-preemption configuration.
module tb_rr_ring_arbiter;
  logic       clk;
  logic       rst_n;
  logic [3:0] req;

  int n_compared;
  int n_mismatched;

  rr_ring_arbiter_if #(.N(4)) arb8_if ();
  rr_ring_arbiter_if #(.N(4)) arb0_if ();

  assign arb8_if.req = req;
  assign arb0_if.req = req;

  rr_ring_arbiter #(.N(4), .MAX_HOLD(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (arb8_if)
  );

  rr_ring_arbiter #(.N(4), .MAX_HOLD(0)) dut_nohold (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (arb0_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] idx;
    logic       valid;
    logic [3:0] ptr;
  } vec_t;

  vec_t vecs [15];

  // Drive a request, let one rising edge pass, and settle 1 time unit after it.
  task automatic apply_stimulus(input logic [3:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name,
                              input logic [3:0] ag, input logic [1:0] ai,
                              input logic av, input logic [3:0] ap,
                              input logic [3:0] eg, input logic [1:0] ei,
                              input logic ev, input logic [3:0] ep);
    n_compared++;
    if ({ag, ai, av, ap} !== {eg, ei, ev, ep}) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got grant=%b idx=%0d valid=%b ptr=%b, expected grant=%b idx=%0d valid=%b ptr=%b",
               name, ag, ai, av, ap, eg, ei, ev, ep);
    end
  endtask

  task automatic check_grant(input string name, input logic [3:0] ag, input logic [3:0] eg);
    n_compared++;
    if (ag !== eg) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got grant=%b, expected grant=%b", name, ag, eg);
    end
  endtask

  initial begin
    logic [3:0] exp_g;
    logic [3:0] exp_p;
    int         b;

    n_compared   = 0;
    n_mismatched = 0;
    req          = 4'b0000;
    rst_n        = 1'b0;

    vecs[0]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0001};
    vecs[1]  = '{4'b1010, 4'b0010, 2'd1, 1'b1, 4'b0100};
    vecs[2]  = '{4'b0010, 4'b0010, 2'd1, 1'b1, 4'b0100};
    vecs[3]  = '{4'b1010, 4'b0010, 2'd1, 1'b1, 4'b0100};
    vecs[4]  = '{4'b1000, 4'b1000, 2'd3, 1'b1, 4'b0001};
    vecs[5]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0001};
    vecs[6]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 4'b1000};
    vecs[7]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 4'b1000};
    vecs[8]  = '{4'b0101, 4'b0001, 2'd0, 1'b1, 4'b0010};
    vecs[9]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0010};
    vecs[10] = '{4'b1001, 4'b1000, 2'd3, 1'b1, 4'b0001};
    vecs[11] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0001};
    vecs[12] = '{4'b0110, 4'b0010, 2'd1, 1'b1, 4'b0100};
    vecs[13] = '{4'b0100, 4'b0100, 2'd2, 1'b1, 4'b1000};
    vecs[14] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 4'b1000};

    repeat (2) @(posedge clk);
    #1;
    check_output("reset", arb8_if.grant, arb8_if.grant_idx, arb8_if.grant_valid, arb8_if.ptr,
                 4'b0000, 2'd0, 1'b0, 4'b0001);
    check_output("reset_nohold", arb0_if.grant, arb0_if.grant_idx, arb0_if.grant_valid, arb0_if.ptr,
                 4'b0000, 2'd0, 1'b0, 4'b0001);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      apply_stimulus(vecs[i].req);
      check_output($sformatf("vec%0d", i), arb8_if.grant, arb8_if.grant_idx,
                   arb8_if.grant_valid, arb8_if.ptr,
                   vecs[i].grant, vecs[i].idx, vecs[i].valid, vecs[i].ptr);
    end

    // Asynchronous reset while a grant is held must clear it before the next edge.
    apply_stimulus(4'b0010);
    check_output("pre_reset_grant", arb8_if.grant, arb8_if.grant_idx, arb8_if.grant_valid, arb8_if.ptr,
                 4'b0010, 2'd1, 1'b1, 4'b0100);
    #2 rst_n = 1'b0;
    #1;
    check_output("reset_mid_grant", arb8_if.grant, arb8_if.grant_idx, arb8_if.grant_valid, arb8_if.ptr,
                 4'b0000, 2'd0, 1'b0, 4'b0001);
    req = 4'b0000;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // All requesters active: each owner keeps the grant for exactly 8 cycles.
    req = 4'b1111;
    for (int c = 1; c <= 64; c++) begin
      @(posedge clk);
      #1;
      b     = ((c - 1) / 8) % 4;
      exp_g = 4'b0001 << b;
      exp_p = 4'b0001 << ((b + 1) % 4);
      check_output($sformatf("rotate_c%0d", c), arb8_if.grant, arb8_if.grant_idx,
                   arb8_if.grant_valid, arb8_if.ptr, exp_g, 2'(b), 1'b1, exp_p);
      check_grant($sformatf("nohold_keep_c%0d", c), arb0_if.grant, 4'b0001);
    end

    // Without a hold limit the first owner only leaves on its own release.
    apply_stimulus(4'b1110);
    check_output("nohold_release", arb0_if.grant, arb0_if.grant_idx, arb0_if.grant_valid, arb0_if.ptr,
                 4'b0010, 2'd1, 1'b1, 4'b0100);

    apply_stimulus(4'b0000);
    check_output("idle_before_lone", arb8_if.grant, arb8_if.grant_idx, arb8_if.grant_valid, arb8_if.ptr,
                 4'b0000, 2'd0, 1'b0, arb8_if.ptr);

    // Lone owner keeps the grant well past the hold limit.
    req = 4'b0100;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      check_grant($sformatf("lone_c%0d", c), arb8_if.grant, 4'b0100);
    end
    apply_stimulus(4'b0101);
    check_output("lone_preempt", arb8_if.grant, arb8_if.grant_idx, arb8_if.grant_valid, arb8_if.ptr,
                 4'b0001, 2'd0, 1'b1, 4'b0010);

    apply_stimulus(4'b0000);
    check_output("final_idle", arb8_if.grant, arb8_if.grant_idx, arb8_if.grant_valid, arb8_if.ptr,
                 4'b0000, 2'd0, 1'b0, 4'b0010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
